// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-game round sequencer.
package reaction_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StArm    = 3'd1,
    StGo     = 3'd2,
    StResult = 3'd3,
    StFoul   = 3'd4,
    StDone   = 3'd5
  } state_e;

  localparam int unsigned TIME_W = 14;
  localparam logic [TIME_W-1:0] MS_MAX = TIME_W'(9999);

  localparam int unsigned TICK_HW  = 50000;
  localparam int unsigned TICK_SIM = 5;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Fibonacci LFSR, taps 16,14,13,11; never reaches zero from a non-zero seed.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/reaction_round_ctrl_if.sv
// Player/display-side signal bundle of the round sequencer.
interface reaction_round_ctrl_if;
  import reaction_pkg::*;

  logic              start;
  logic              stop;
  logic              go;
  logic [TIME_W-1:0] run_ms;
  logic [TIME_W-1:0] result;
  logic [TIME_W-1:0] best;
  logic [2:0]        round;
  state_e            state;
  logic              valid;
  logic              false_start;
  logic              done;

  modport master (
    output start, stop,
    input  go, run_ms, result, best, round, state, valid, false_start, done
  );

  modport slave (
    input  start, stop,
    output go, run_ms, result, best, round, state, valid, false_start, done
  );

endinterface

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every Period cycles, restarted by clr.
module ms_tick_gen #(
  parameter int unsigned Period = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = (Period > 1) ? $clog2(Period) : 1;
  localparam logic [CntW-1:0] Last = CntW'(Period - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == Last);

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/reaction_round_ctrl.sv
// Multi-round reaction-game sequencer: random hold-off, GO lamp, ms timing, best tracking.
// Build option FALSE_START_PENALTY_EN: a false start scores MS_MAX and completes the round.
module reaction_round_ctrl
  import reaction_pkg::*;
#(
  parameter int unsigned SIM_MODE     = 0,
  parameter int unsigned ROUNDS       = 4,
  parameter int unsigned MIN_DELAY_MS = 1000,
  parameter int unsigned DELAY_BITS   = 11
) (
  input logic                   clk,
  input logic                   rst_n,
  reaction_round_ctrl_if.slave  bus
);

  localparam int unsigned TickPeriod = (SIM_MODE != 0) ? TICK_SIM : TICK_HW;
  localparam logic [15:0] RandMask   = 16'((32'd1 << DELAY_BITS) - 32'd1);
  localparam logic [2:0]  LastRound  = 3'(ROUNDS - 1);

  state_e            state_q, state_d;
  logic [15:0]       delay_q, delay_d;
  logic [TIME_W-1:0] run_ms_q, run_ms_d;
  logic [TIME_W-1:0] result_q, result_d;
  logic [TIME_W-1:0] best_q, best_d;
  logic [2:0]        round_q, round_d;
  logic              valid_q, valid_d;
  logic              false_q, false_d;
  logic [15:0]       lfsr_q;
  logic              tick;
  logic [16:0]       delay_sum;
  logic [15:0]       delay_load;

  assign delay_sum  = 17'(MIN_DELAY_MS) + {1'b0, lfsr_q & RandMask};
  assign delay_load = delay_sum[16] ? 16'hFFFF : delay_sum[15:0];

  // Prescaler restarts on every state change so each state sees a full first period.
  ms_tick_gen #(
    .Period (TickPeriod)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_d != state_q),
    .tick  (tick)
  );

  always_comb begin
    state_d  = state_q;
    delay_d  = delay_q;
    run_ms_d = run_ms_q;
    result_d = result_q;
    best_d   = best_q;
    round_d  = round_q;
    valid_d  = 1'b0;
    false_d  = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d = StArm;
          round_d = '0;
          best_d  = MS_MAX;
          delay_d = delay_load;
        end
      end
      StArm: begin
        if (bus.stop) begin
          false_d = 1'b1;
`ifdef FALSE_START_PENALTY_EN
          state_d  = StResult;
          result_d = MS_MAX;
          valid_d  = 1'b1;
`else
          state_d  = StFoul;
`endif
        end else if (tick) begin
          if (delay_q <= 16'd1) begin
            state_d  = StGo;
            delay_d  = '0;
            run_ms_d = '0;
          end else begin
            delay_d = delay_q - 16'd1;
          end
        end
      end
      StGo: begin
        if (bus.stop || run_ms_q == MS_MAX) begin
          state_d  = StResult;
          result_d = run_ms_q;
          valid_d  = 1'b1;
          if (run_ms_q < best_q) best_d = run_ms_q;
        end else if (tick) begin
          run_ms_d = run_ms_q + TIME_W'(1);
        end
      end
      StResult: begin
        if (bus.start) begin
          if (round_q == LastRound) begin
            state_d = StDone;
          end else begin
            state_d = StArm;
            round_d = round_q + 3'd1;
            delay_d = delay_load;
          end
        end
      end
      StFoul: begin
        if (bus.start) begin
          state_d = StArm;
          delay_d = delay_load;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      delay_q  <= '0;
      run_ms_q <= '0;
      result_q <= '0;
      best_q   <= MS_MAX;
      round_q  <= '0;
      valid_q  <= 1'b0;
      false_q  <= 1'b0;
      lfsr_q   <= LFSR_SEED;
    end else begin
      state_q  <= state_d;
      delay_q  <= delay_d;
      run_ms_q <= run_ms_d;
      result_q <= result_d;
      best_q   <= best_d;
      round_q  <= round_d;
      valid_q  <= valid_d;
      false_q  <= false_d;
      lfsr_q   <= lfsr_next(lfsr_q);
    end
  end

  assign bus.go          = (state_q == StGo);
  assign bus.run_ms      = run_ms_q;
  assign bus.result      = result_q;
  assign bus.best        = best_q;
  assign bus.round       = round_q;
  assign bus.state       = state_q;
  assign bus.valid       = valid_q;
  assign bus.false_start = false_q;
  assign bus.done        = (state_q == StDone);

endmodule
